timer_apb_sequencer: RTL and testbench

TIMER_APB_SEQUENCER -- requirements
Module: timer_apb_sequencer

---
 rtl/timer_pkg.sv | 31 +++
 rtl/apb_master_xfer.sv | 65 ++++++
 rtl/timer_apb_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_timer_apb_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Timer register map, TCR/TSR bit positions and sequencer states.
// Shared by the APB sequencer and its single-transfer master.
package timer_pkg;

  localparam logic [7:0] TDR_OFS = 8'h00;
  localparam logic [7:0] TCR_OFS = 8'h01;
  localparam logic [7:0] TSR_OFS = 8'h02;

  localparam int TCR_LOAD_BIT = 7;
  localparam int TCR_DOWN_BIT = 5;
  localparam int TCR_EN_BIT   = 4;
  localparam int TSR_OVF_BIT  = 0;
  localparam int TSR_UNF_BIT  = 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_STOP0, ST_WR_TDR, ST_LOAD, ST_CLR_TSR, ST_RUN,
    ST_WAIT, ST_POLL, ST_ACK, ST_STOP, ST_FIN
  } seq_state_t;

  function automatic logic [7:0] tcr_val(input logic load, input logic en,
                                         input logic down, input logic [1:0] cks);
    logic [7:0] v;
    v = 8'h00;
    v[TCR_LOAD_BIT] = load;
    v[TCR_EN_BIT]   = en;
    v[TCR_DOWN_BIT] = down;
    v[1:0]          = cks;
    return v;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// One APB transfer per request: SETUP then ACCESS held until pready; >=2 cycles.
// Accepts a new request only from idle, so transfers are always separated by an idle cycle.
module apb_master_xfer
  import timer_pkg::*;
(
  input  logic       pclk,
  input  logic       presetn,
  input  logic       i_req,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_write,
  output logic       o_ack,
  output logic [7:0] o_rdata,
  output logic       o_slverr,
  output logic       o_psel,
  output logic       o_penable,
  output logic       o_pwrite,
  output logic [7:0] o_paddr,
  output logic [7:0] o_pwdata,
  input  logic [7:0] i_prdata,
  input  logic       i_pready,
  input  logic       i_pslverr
);

  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  logic [7:0] r_paddr;
  logic [7:0] r_pwdata;
  logic       w_done;

  assign w_done = r_psel & r_penable & i_pready;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 8'h00;
      r_pwdata  <= 8'h00;
    end else if (!r_psel) begin
      if (i_req) begin
        r_psel   <= 1'b1;
        r_pwrite <= i_write;
        r_paddr  <= i_addr;
        r_pwdata <= i_write ? i_wdata : 8'h00;
      end
    end else if (!r_penable) begin
      r_penable <= 1'b1;
    end else if (i_pready) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  assign o_ack     = w_done;
  assign o_rdata   = i_prdata;
  assign o_slverr  = w_done & i_pslverr;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Programs a timer over APB, polls TSR every POLL_GAP idle cycles and acks events.
// Stalls on pready; abort or pslverr finishes the in-flight transfer, then stops the timer.
module timer_apb_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 4,
  parameter logic [7:0]  ADDR_BASE = 8'h00
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic [7:0] cfg_tdr,
  input  logic       cfg_down,
  input  logic [1:0] cfg_cks,
  input  logic [7:0] cfg_repeat,
  input  logic       abort,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       done,
  output logic [7:0] event_cnt,
  output logic       err,
  output logic       aborted
);

  seq_state_t r_state;
  logic [7:0] r_tdr;
  logic       r_down;
  logic [1:0] r_cks;
  logic [7:0] r_repeat;
  logic [7:0] r_event_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       r_aborted;
  logic       r_abort_pend;

  logic       w_req;
  logic       w_write;
  logic [7:0] w_ofs;
  logic [7:0] w_wdata;
  logic [7:0] w_addr;
  logic       w_ack;
  logic [7:0] w_rdata;
  logic       w_slverr;
  logic [7:0] w_evt_mask;
  logic       w_evt;
  logic       w_stop_req;

  always_comb begin
    w_req   = 1'b1;
    w_write = 1'b1;
    w_ofs   = TCR_OFS;
    w_wdata = 8'h00;
    case (r_state)
      ST_STOP0, ST_STOP: ;
      ST_WR_TDR: begin
        w_ofs   = TDR_OFS;
        w_wdata = r_tdr;
      end
      ST_LOAD:             w_wdata = tcr_val(1'b1, 1'b0, 1'b0, r_cks);
      ST_CLR_TSR, ST_ACK:  w_ofs   = TSR_OFS;
      ST_RUN:              w_wdata = tcr_val(1'b0, 1'b1, r_down, r_cks);
      ST_POLL: begin
        w_ofs   = TSR_OFS;
        w_write = 1'b0;
      end
      default:             w_req   = 1'b0;
    endcase
  end

  assign w_addr     = ADDR_BASE + w_ofs;
  // Only the flag matching the count direction matters; the other is ignored.
  assign w_evt_mask = r_down ? (8'h01 << TSR_UNF_BIT) : (8'h01 << TSR_OVF_BIT);
  assign w_evt      = |(w_rdata & w_evt_mask);
  assign w_stop_req = abort | r_abort_pend;

  apb_master_xfer u_xfer (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_req     (w_req),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_write   (w_write),
    .o_ack     (w_ack),
    .o_rdata   (w_rdata),
    .o_slverr  (w_slverr),
    .o_psel    (psel),
    .o_penable (penable),
    .o_pwrite  (pwrite),
    .o_paddr   (paddr),
    .o_pwdata  (pwdata),
    .i_prdata  (prdata),
    .i_pready  (pready),
    .i_pslverr (pslverr)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= ST_IDLE;
      r_tdr        <= 8'h00;
      r_down       <= 1'b0;
      r_cks        <= 2'b00;
      r_repeat     <= 8'h00;
      r_event_cnt  <= 8'h00;
      r_wait_cnt   <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && abort)
        r_abort_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tdr        <= cfg_tdr;
            r_down       <= cfg_down;
            r_cks        <= cfg_cks;
            r_repeat     <= cfg_repeat;
            r_event_cnt  <= 8'h00;
            r_err        <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_STOP0;
          end
        end
        ST_WAIT: begin
          if (w_stop_req) begin
            r_state <= ST_STOP;
          end else if (r_wait_cnt == 8'(POLL_GAP - 1)) begin
            r_wait_cnt <= 8'h00;
            r_state    <= ST_POLL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          if (w_ack) begin
            if (w_slverr)
              r_err <= 1'b1;
            // A failed STOP write cannot be retried usefully, so it ends the sequence too.
            if (r_state == ST_STOP) begin
              r_state   <= ST_FIN;
              r_done    <= 1'b1;
              r_aborted <= r_abort_pend | abort | w_slverr | r_err;
            end else if (w_slverr || w_stop_req) begin
              r_state <= ST_STOP;
            end else begin
              r_wait_cnt <= 8'h00;
              case (r_state)
                ST_STOP0:   r_state <= ST_WR_TDR;
                ST_WR_TDR:  r_state <= ST_LOAD;
                ST_LOAD:    r_state <= ST_CLR_TSR;
                ST_CLR_TSR: r_state <= ST_RUN;
                ST_RUN:     r_state <= ST_WAIT;
                ST_POLL: begin
                  if (w_evt) begin
                    r_event_cnt <= (r_event_cnt == 8'hFF) ? 8'hFF : r_event_cnt + 8'd1;
                    r_state     <= ST_ACK;
                  end else begin
                    r_state <= ST_WAIT;
                  end
                end
                ST_ACK: begin
                  if (r_repeat != 8'h00 && r_event_cnt == r_repeat)
                    r_state <= ST_STOP;
                  else
                    r_state <= ST_WAIT;
                end
                default:    r_state <= ST_STOP;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign event_cnt = r_event_cnt;
  assign err       = r_err;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Directed bench: APB timer slave model, protocol monitor and hand-computed write logs.
module tb_timer_apb_sequencer;

  localparam logic [7:0] AB = 8'h40;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       start, abort, cfg_down;
  logic [7:0] cfg_tdr, cfg_repeat;
  logic [1:0] cfg_cks;
  logic       psel, penable, pwrite, pready, pslverr;
  logic [7:0] paddr, pwdata, prdata;
  logic       busy, done, err, aborted;
  logic [7:0] event_cnt;

  always #5 pclk = ~pclk;

  timer_apb_sequencer #(.POLL_GAP(4), .ADDR_BASE(AB)) dut (
    .pclk(pclk), .presetn(presetn), .start(start), .cfg_tdr(cfg_tdr),
    .cfg_down(cfg_down), .cfg_cks(cfg_cks), .cfg_repeat(cfg_repeat), .abort(abort),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy), .done(done),
    .event_cnt(event_cnt), .err(err), .aborted(aborted)
  );

  // Timer slave model with optional wait-state / error injection.
  logic [7:0] m_tdr = 8'h00, m_tcr = 8'h00, m_tsr = 8'h00, m_cnt = 8'h00;
  int         acc_cycles = 0;
  logic       stall_en = 1'b0, err_en = 1'b0;
  logic [7:0] stall_addr = 8'h00, err_addr = 8'h00;
  int         stall_n = 0;

  assign pready  = !(stall_en && psel && penable && paddr == stall_addr && acc_cycles < stall_n);
  assign pslverr = err_en && psel && penable && pready && pwrite && paddr == err_addr;
  assign prdata  = (paddr == AB + 8'd2) ? m_tsr : (paddr == AB + 8'd1) ? m_tcr : m_tdr;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cycles <= acc_cycles + 1;
    else                            acc_cycles <= 0;
  end

  always @(posedge pclk) begin : timer_model
    logic [7:0] t;
    logic       wr;
    wr = psel && penable && pready && pwrite;
    t  = m_tsr;
    if (wr && paddr == AB + 8'd2) t = pwdata;
    if (wr && paddr == AB)        m_tdr <= pwdata;
    if (wr && paddr == AB + 8'd1) m_tcr <= pwdata;
    if (wr && paddr == AB + 8'd1 && pwdata[7]) begin
      m_cnt <= m_tdr;
    end else if (m_tcr[4]) begin
      if (m_tcr[5]) begin
        if (m_cnt == 8'h00) begin m_cnt <= m_tdr; t[1] = 1'b1; end
        else m_cnt <= m_cnt - 8'd1;
      end else begin
        if (m_cnt == 8'hFF) begin m_cnt <= m_tdr; t[0] = 1'b1; end
        else m_cnt <= m_cnt + 8'd1;
      end
    end
    m_tsr <= t;
  end

  // APB monitor: logs completed writes and counts protocol violations.
  int          viol = 0, psel_cycles = 0, n_done = 0, acc_len = 0;
  logic        prev_psel = 1'b0, prev_cmpl = 1'b0, prev_wr = 1'b0;
  logic [7:0]  prev_addr = 8'h00, prev_wd = 8'h00;
  logic [15:0] wq[$];
  int          wlen_q[$];

  always @(negedge pclk) begin
    if (!presetn) begin
      prev_psel = 1'b0;
      prev_cmpl = 1'b0;
      acc_len   = 0;
    end else begin
      if (penable && !psel) viol++;
      if (psel && !penable && prev_psel) viol++;
      if (psel && penable) begin
        if (!prev_psel || prev_cmpl || paddr != prev_addr || pwdata != prev_wd || pwrite != prev_wr)
          viol++;
        acc_len++;
      end
      prev_cmpl = psel && penable && pready;
      if (prev_cmpl) begin
        if (pwrite) begin
          wq.push_back({paddr, pwdata});
          wlen_q.push_back(acc_len);
        end
        acc_len = 0;
      end
      if (psel) psel_cycles++;
      if (done) n_done++;
      prev_psel = psel;
      prev_addr = paddr;
      prev_wd   = pwdata;
      prev_wr   = pwrite;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] tdr, input logic down, input logic [1:0] cks,
                          input logic [7:0] rep, input logic ab);
    @(negedge pclk);
    cfg_tdr = tdr; cfg_down = down; cfg_cks = cks; cfg_repeat = rep;
    start = 1'b1; abort = ab;
    @(negedge pclk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge pclk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] wr_at(input int idx);
    if (idx < wq.size()) return {16'h0000, wq[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int base, nd, ps, k, ntsr;
    logic [15:0] e38 [7];
    e38 = '{16'h4100, 16'h40FF, 16'h4180, 16'h4200, 16'h4130, 16'h4200, 16'h4100};

    presetn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_tdr = 8'h00; cfg_down = 1'b0; cfg_cks = 2'b00; cfg_repeat = 8'h00;
    repeat (3) @(negedge pclk);
    check("rst_apb", {23'd0, psel, penable, pwrite, paddr, pwdata}, 32'd0);
    check("rst_stat", {20'd0, busy, done, err, aborted, event_cnt}, 32'd0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    // Down count from FF, one underflow event.
    base = wq.size(); nd = n_done;
    do_start(8'hFF, 1'b1, 2'd0, 8'd1, 1'b0);
    check("t38_busy", 32'(busy), 32'd1);
    wait_done("t38", 2000);
    check("t38_evt", 32'(event_cnt), 32'd1);
    check("t38_aborted", 32'(aborted), 32'd0);
    repeat (2) @(negedge pclk);
    check("t38_nwr", 32'(wq.size() - base), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t38_wr%0d", i), wr_at(base + i), {16'h0000, e38[i]});
    check("t38_ndone", 32'(n_done - nd), 32'd1);

    // Up count, three events; abort coincident with start is ignored.
    base = wq.size(); nd = n_done;
    do_start(8'hF0, 1'b0, 2'd0, 8'd3, 1'b1);
    wait_done("t39", 2000);
    check("t39_evt", 32'(event_cnt), 32'd3);
    check("t39_aborted", 32'(aborted), 32'd0);
    repeat (3) @(negedge pclk);
    ntsr = 0;
    for (int i = base; i < wq.size(); i++)
      if (wq[i] == 16'h4200) ntsr++;
    check("t39_tsr_clears", 32'(ntsr), 32'd4);
    check("t39_busy_low", 32'(busy), 32'd0);
    check("t39_ndone", 32'(n_done - nd), 32'd1);

    // Free-run, abort in WAIT after two events.
    base = wq.size();
    do_start(8'hF0, 1'b0, 2'd2, 8'd0, 1'b0);
    k = 0;
    while (event_cnt != 8'd2 && k < 1000) begin @(negedge pclk); k++; end
    check("t40_reach2", 32'(event_cnt), 32'd2);
    k = 0;
    while (!(psel && penable && pready) && k < 50) begin @(negedge pclk); k++; end
    @(negedge pclk);
    abort = 1'b1;
    wait_done("t40", 200);
    check("t40_aborted", 32'(aborted), 32'd1);
    check("t40_evt", 32'(event_cnt), 32'd2);
    abort = 1'b0;
    @(negedge pclk);
    check("t40_last_wr", wr_at(wq.size() - 1), 32'h4100);
    check("t40_ack_wr", wr_at(wq.size() - 2), 32'h4200);

    // Wait states then slave error on the TDR write.
    stall_en = 1'b1; stall_addr = AB; stall_n = 5; err_en = 1'b1; err_addr = AB;
    base = wq.size();
    do_start(8'hAA, 1'b0, 2'd1, 8'd0, 1'b0);
    wait_done("t41", 200);
    check("t41_err", 32'(err), 32'd1);
    check("t41_aborted", 32'(aborted), 32'd1);
    stall_en = 1'b0; err_en = 1'b0;
    @(negedge pclk);
    check("t41_nwr", 32'(wq.size() - base), 32'd3);
    check("t41_tdr_wr", wr_at(base + 1), 32'h40AA);
    check("t41_tdr_len", (base + 1 < wlen_q.size()) ? 32'(wlen_q[base + 1]) : 32'hDEAD_BEEF, 32'd6);
    check("t41_stop_wr", wr_at(base + 2), 32'h4100);

    // Start pulses while busy and in the done cycle are ignored.
    base = wq.size(); nd = n_done;
    do_start(8'hF0, 1'b0, 2'd1, 8'd1, 1'b0);
    check("t43_err_clr", 32'(err), 32'd0);
    repeat (3) @(negedge pclk);
    cfg_tdr = 8'h11; cfg_down = 1'b1; cfg_cks = 2'd3; cfg_repeat = 8'd5; start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    wait_done("t43", 2000);
    check("t43_evt", 32'(event_cnt), 32'd1);
    ps = psel_cycles;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    repeat (10) @(negedge pclk);
    check("t43_busy_low", 32'(busy), 32'd0);
    check("t43_quiet", 32'(psel_cycles - ps), 32'd0);
    check("t43_ndone", 32'(n_done - nd), 32'd1);
    check("t43_tdr_wr", wr_at(base + 1), 32'h40F0);
    check("t43_run_wr", wr_at(base + 4), 32'h4111);

    // Reset during the LOAD access.
    do_start(8'h33, 1'b0, 2'd2, 8'd0, 1'b0);
    k = 0;
    while (!(psel && penable && paddr == AB + 8'd1 && pwdata == 8'h82) && k < 50) begin
      @(negedge pclk); k++;
    end
    check("t42_in_load", {16'd0, 6'd0, psel, penable, pwdata}, {16'd0, 6'd0, 2'b11, 8'h82});
    presetn = 1'b0;
    #1;
    check("t42_apb", {23'd0, psel, penable, pwrite, paddr, pwdata}, 32'd0);
    check("t42_stat", {20'd0, busy, done, err, aborted, event_cnt}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    ps = psel_cycles;
    repeat (20) @(negedge pclk);
    check("t42_quiet", 32'(psel_cycles - ps), 32'd0);
    check("t42_busy", 32'(busy), 32'd0);

    check("apb_protocol_viol", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
